// File: rtl/gold_stone_placer.sv
// Gold/stone placer: LFSR-driven (x,y) picker and SIZE x SIZE sprite painter for the VGA adapter.
// Build option: define LFSR_AUTORUN_EN to free-run the LFSR every cycle (enable_random then only latches).
module gold_stone_placer #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter logic [7:0]  X_MIN   = 8'd16,
  parameter logic [6:0]  Y_MIN   = 7'd40,
  parameter logic [3:0]  SIZE    = 4'd8,
  parameter logic [2:0]  GOLD_C  = 3'b110,
  parameter logic [2:0]  STONE_C = 3'b111
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       resetn_gold_stone_i,
  input  logic       enable_random_i,
  input  logic       enable_draw_gold_i,
  input  logic       enable_draw_stone_i,
  output logic       draw_gold_done_o,
  output logic       draw_stone_done_o,
  output logic [2:0] gold_count_o,
  output logic [2:0] stone_count_o,
  output logic [7:0] vga_x_o,
  output logic [6:0] vga_y_o,
  output logic [2:0] vga_colour_o,
  output logic       vga_plot_o
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic        sel_y_q, sel_y_d;
  logic        kind_gold_q, kind_gold_d;
  logic [3:0]  col_q, col_d;
  logic [3:0]  row_q, row_d;
  logic        gold_done_q, gold_done_d;
  logic        stone_done_q, stone_done_d;
  logic [2:0]  gold_cnt_q, gold_cnt_d;
  logic [2:0]  stone_cnt_q, stone_cnt_d;

  logic [15:0] lfsr_step;
  logic [6:0]  lat;
  logic        draw_req;
  logic        start;
  logic        last_col;

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    x_d          = x_q;
    y_d          = y_q;
    sel_y_d      = sel_y_q;
    kind_gold_d  = kind_gold_q;
    col_d        = col_q;
    row_d        = row_q;
    gold_done_d  = gold_done_q;
    stone_done_d = stone_done_q;
    gold_cnt_d   = gold_cnt_q;
    stone_cnt_d  = stone_cnt_q;

    lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
`ifdef LFSR_AUTORUN_EN
    lfsr_d = lfsr_step;
    lat    = lfsr_q[6:0];
`else
    lat = lfsr_step[6:0];
    if (enable_random_i) lfsr_d = lfsr_step;
`endif

    if (enable_random_i) begin
      if (sel_y_q) y_d = Y_MIN + {1'b0, lat[5:0]};
      else         x_d = X_MIN + {1'b0, lat};
      sel_y_d = ~sel_y_q;
    end

    draw_req = enable_draw_gold_i | enable_draw_stone_i;
    start    = draw_req && (state_q != S_DRAW);
    last_col = (col_q == SIZE - 4'd1);

    if (start) begin
      // Gold wins a simultaneous request; a new draw always restarts coordinate pairing at x.
      state_d      = S_DRAW;
      kind_gold_d  = enable_draw_gold_i;
      col_d        = 4'd0;
      row_d        = 4'd0;
      gold_done_d  = 1'b0;
      stone_done_d = 1'b0;
      sel_y_d      = 1'b0;
    end else begin
      case (state_q)
        S_DRAW: begin
          if (last_col && (row_q == SIZE - 4'd1)) begin
            state_d = S_DONE;
            if (kind_gold_q) begin
              gold_done_d = 1'b1;
              if (gold_cnt_q != 3'd7) gold_cnt_d = gold_cnt_q + 3'd1;
            end else begin
              stone_done_d = 1'b1;
              if (stone_cnt_q != 3'd7) stone_cnt_d = stone_cnt_q + 3'd1;
            end
          end else if (last_col) begin
            col_d = 4'd0;
            row_d = row_q + 4'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
        S_DONE: begin
          if (enable_random_i) begin
            state_d      = S_IDLE;
            gold_done_d  = 1'b0;
            stone_done_d = 1'b0;
          end
        end
        S_IDLE: ;
        default: state_d = S_IDLE;
      endcase
    end

    // Round clear overrides every enable and freezes the coordinate source.
    if (!resetn_gold_stone_i) begin
      state_d      = S_IDLE;
      lfsr_d       = lfsr_q;
      x_d          = x_q;
      y_d          = y_q;
      sel_y_d      = 1'b0;
      gold_done_d  = 1'b0;
      stone_done_d = 1'b0;
      gold_cnt_d   = 3'd0;
      stone_cnt_d  = 3'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      sel_y_q      <= 1'b0;
      kind_gold_q  <= 1'b0;
      col_q        <= 4'd0;
      row_q        <= 4'd0;
      gold_done_q  <= 1'b0;
      stone_done_q <= 1'b0;
      gold_cnt_q   <= 3'd0;
      stone_cnt_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sel_y_q      <= sel_y_d;
      kind_gold_q  <= kind_gold_d;
      col_q        <= col_d;
      row_q        <= row_d;
      gold_done_q  <= gold_done_d;
      stone_done_q <= stone_done_d;
      gold_cnt_q   <= gold_cnt_d;
      stone_cnt_q  <= stone_cnt_d;
    end
  end

  // Pixel outputs are forced to zero outside DRAW so the adapter sees a quiet bus.
  always_comb begin
    vga_plot_o        = (state_q == S_DRAW);
    vga_x_o           = vga_plot_o ? (x_q + {4'd0, col_q}) : 8'd0;
    vga_y_o           = vga_plot_o ? (y_q + {3'd0, row_q}) : 7'd0;
    vga_colour_o      = vga_plot_o ? (kind_gold_q ? GOLD_C : STONE_C) : 3'd0;
    draw_gold_done_o  = gold_done_q;
    draw_stone_done_o = stone_done_q;
    gold_count_o      = gold_cnt_q;
    stone_count_o     = stone_cnt_q;
  end

endmodule
